// File: rtl/apb4_nslv_pkg.sv
// Shared types and helpers for the multi-slave APB4 master.
// FSM state encoding, response codes and a constant log2 helper.
package apb4_nslv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DECERR
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb4_arb_wrr.sv
// Weighted write/read arbiter used in the APB4 master IDLE state.
// Under contention, ratio N lets N+1 writes through before one read.
module apb4_arb_wrr (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       wr_req_i,
  input  logic       rd_req_i,
  input  logic [2:0] ratio_i,
  output logic       wr_gnt_o,
  output logic       rd_gnt_o
);

  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic       rd_turn;

  // wr_cnt holds writes granted since the last read, saturating
  assign rd_turn  = wr_cnt_q > {1'b0, ratio_i};
  assign wr_gnt_o = en_i & wr_req_i & (~rd_req_i | ~rd_turn);
  assign rd_gnt_o = en_i & rd_req_i & (~wr_req_i | rd_turn);

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (rd_gnt_o) begin
      wr_cnt_d = '0;
    end else if (wr_gnt_o && wr_cnt_q != 4'hF) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wr_cnt_q <= '0;
    else         wr_cnt_q <= wr_cnt_d;
  end

endmodule

// File: rtl/apb4_master_nslv.sv
// APB4 master draining AXI-style address/data FIFOs onto NSLV slaves.
// One transfer in flight; decode on upper address bits, PREADY timeout.
module apb4_master_nslv
  import apb4_nslv_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NSLV = 4,
  parameter int TMO  = 256
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  output logic [NSLV-1:0]     PSEL,
  output logic [AW-1:0]       PADDR,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [2:0]          PPROT,
  output logic [DW-1:0]       PWDATA,
  output logic [DW/8-1:0]     PSTRB,
  input  logic [NSLV-1:0]     PREADY,
  input  logic [NSLV*DW-1:0]  PRDATA,
  input  logic [NSLV-1:0]     PSLVERR,
  input  logic [2:0]          wr_rd_ratio,
  input  logic [AW+2:0]       wa_fifo_rdata,
  input  logic                wa_fifo_empty,
  output logic                wa_fifo_pop,
  input  logic [DW/8+DW-1:0]  wd_fifo_rdata,
  input  logic                wd_fifo_empty,
  output logic                wd_fifo_pop,
  input  logic [AW+2:0]       ra_fifo_rdata,
  input  logic                ra_fifo_empty,
  output logic                ra_fifo_pop,
  output logic [DW+1:0]       rd_fifo_wdata,
  input  logic                rd_fifo_full,
  output logic                rd_fifo_push,
  output logic [1:0]          b_fifo_wdata,
  input  logic                b_fifo_full,
  output logic                b_fifo_push
);

  localparam int SW  = clog2(NSLV);
  localparam int SWI = (SW > 0) ? SW : 1;
  localparam int TW  = (TMO > 1) ? clog2(TMO) : 1;
  localparam int SB  = DW / 8;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      prot_q, prot_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SB-1:0]   strb_q, strb_d;
  logic [SWI-1:0]  idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;

  logic            idle, wr_elig, rd_elig;
  logic            wr_gnt, rd_gnt;
  logic [AW-1:0]   new_addr;
  logic [SWI-1:0]  new_idx;
  logic [NSLV-1:0] sel_oh;
  logic            rdy, err, tmo_hit;
  logic [DW-1:0]   rdat;
  logic            push;
  logic [1:0]      resp;
  logic [DW-1:0]   rsp_data;

  assign idle    = (state_q == ST_IDLE) & PRESETn;
  assign wr_elig = ~wa_fifo_empty & ~wd_fifo_empty & ~b_fifo_full;
  assign rd_elig = ~ra_fifo_empty & ~rd_fifo_full;

  apb4_arb_wrr u_arb (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .en_i     (idle),
    .wr_req_i (wr_elig),
    .rd_req_i (rd_elig),
    .ratio_i  (wr_rd_ratio),
    .wr_gnt_o (wr_gnt),
    .rd_gnt_o (rd_gnt)
  );

  assign new_addr = wr_gnt ? wa_fifo_rdata[AW-1:0] : ra_fifo_rdata[AW-1:0];

  if (NSLV > 1) begin : g_dec
    assign new_idx = new_addr[AW-1 -: SWI];
  end else begin : g_dec1
    assign new_idx = '0;
  end

  always_comb begin
    rdy    = 1'b0;
    err    = 1'b0;
    rdat   = '0;
    sel_oh = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == SWI'(i)) begin
        sel_oh[i] = 1'b1;
        rdy       = PREADY[i];
        err       = PSLVERR[i];
        rdat      = PRDATA[i*DW +: DW];
      end
    end
  end

  assign tmo_hit = (TMO != 0) && (tmr_q == TW'(TMO - 1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    prot_d   = prot_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    push     = 1'b0;
    resp     = RESP_OKAY;
    rsp_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_gnt || rd_gnt) begin
          addr_d  = new_addr;
          wr_d    = wr_gnt;
          prot_d  = wr_gnt ? wa_fifo_rdata[AW +: 3] : ra_fifo_rdata[AW +: 3];
          wdata_d = wr_gnt ? wd_fifo_rdata[DW-1:0] : '0;
          strb_d  = wr_gnt ? wd_fifo_rdata[DW +: SB] : '0;
          idx_d   = new_idx;
          tmr_d   = '0;
          state_d = (32'(new_idx) < NSLV) ? ST_SETUP : ST_DECERR;
        end
      end
      ST_SETUP: begin
        tmr_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (rdy) begin
          push     = 1'b1;
          resp     = err ? RESP_SLVERR : RESP_OKAY;
          rsp_data = rdat;
          state_d  = ST_IDLE;
        end else if (tmo_hit) begin
          push    = 1'b1;
          resp    = RESP_SLVERR;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_DECERR: begin
        push    = 1'b1;
        resp    = RESP_DECERR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      prot_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      prot_q  <= prot_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
    end
  end

  assign PSEL    = (state_q == ST_SETUP || state_q == ST_ACCESS) ? sel_oh : '0;
  assign PENABLE = (state_q == ST_ACCESS);
  assign PADDR   = addr_q;
  assign PWRITE  = wr_q;
  assign PPROT   = prot_q;
  assign PWDATA  = wdata_q;
  assign PSTRB   = strb_q;

  assign wa_fifo_pop = wr_gnt;
  assign wd_fifo_pop = wr_gnt;
  assign ra_fifo_pop = rd_gnt;

  assign b_fifo_push   = push & wr_q;
  assign b_fifo_wdata  = (push & wr_q) ? resp : 2'b00;
  assign rd_fifo_push  = push & ~wr_q;
  assign rd_fifo_wdata = (push & ~wr_q) ? {resp, rsp_data} : '0;

endmodule

// File: tb/tb_apb4_master_nslv.sv
// Scoreboard bench for apb4_master_nslv with three slaves and TMO=8.
// FIFOs and slaves are modelled in the bench; responses land in queues.
module tb_apb4_master_nslv;

  typedef logic [74:0] acc_t;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [2:0]  PSEL;
  logic [31:0] PADDR;
  logic        PENABLE, PWRITE;
  logic [2:0]  PPROT;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PREADY;
  logic [95:0] PRDATA;
  logic [2:0]  PSLVERR;
  logic [2:0]  wr_rd_ratio;
  logic [34:0] wa_fifo_rdata = '0;
  logic        wa_fifo_empty = 1'b1;
  logic        wa_fifo_pop;
  logic [35:0] wd_fifo_rdata = '0;
  logic        wd_fifo_empty = 1'b1;
  logic        wd_fifo_pop;
  logic [34:0] ra_fifo_rdata = '0;
  logic        ra_fifo_empty = 1'b1;
  logic        ra_fifo_pop;
  logic [33:0] rd_fifo_wdata;
  logic        rd_fifo_full;
  logic        rd_fifo_push;
  logic [1:0]  b_fifo_wdata;
  logic        b_fifo_full;
  logic        b_fifo_push;

  logic [34:0] wa_q[$];
  logic [35:0] wd_q[$];
  logic [34:0] ra_q[$];
  logic [1:0]  exp_b[$];
  logic [1:0]  act_b[$];
  logic [33:0] exp_r[$];
  logic [33:0] act_r[$];
  acc_t        exp_acc[$];
  acc_t        acc_q[$];
  logic        grants[$];

  int checks = 0;
  int failures = 0;

  apb4_master_nslv #(.AW(32), .DW(32), .NSLV(3), .TMO(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PPROT(PPROT), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .wr_rd_ratio(wr_rd_ratio),
    .wa_fifo_rdata(wa_fifo_rdata), .wa_fifo_empty(wa_fifo_empty),
    .wa_fifo_pop(wa_fifo_pop),
    .wd_fifo_rdata(wd_fifo_rdata), .wd_fifo_empty(wd_fifo_empty),
    .wd_fifo_pop(wd_fifo_pop),
    .ra_fifo_rdata(ra_fifo_rdata), .ra_fifo_empty(ra_fifo_empty),
    .ra_fifo_pop(ra_fifo_pop),
    .rd_fifo_wdata(rd_fifo_wdata), .rd_fifo_full(rd_fifo_full),
    .rd_fifo_push(rd_fifo_push),
    .b_fifo_wdata(b_fifo_wdata), .b_fifo_full(b_fifo_full),
    .b_fifo_push(b_fifo_push)
  );

  always #5 PCLK = ~PCLK;

  // slave i returns {A0+i, PADDR[23:0]}
  always_comb begin
    PRDATA = '0;
    for (int i = 0; i < 3; i++) begin
      PRDATA[i*32 +: 32] = {8'hA0 + 8'(i), PADDR[23:0]};
    end
  end

  always @(posedge PCLK) begin
    if (wa_fifo_pop) grants.push_back(1'b1);
    if (ra_fifo_pop) grants.push_back(1'b0);
    if (b_fifo_push) act_b.push_back(b_fifo_wdata);
    if (rd_fifo_push) act_r.push_back(rd_fifo_wdata);
    if (PENABLE && (PSEL & PREADY) != 3'b000)
      acc_q.push_back({PSEL, PWRITE, PPROT, PADDR, PWDATA, PSTRB});
    if (wa_fifo_pop && wa_q.size() != 0) wa_q.delete(0);
    if (wd_fifo_pop && wd_q.size() != 0) wd_q.delete(0);
    if (ra_fifo_pop && ra_q.size() != 0) ra_q.delete(0);
    wa_fifo_empty <= (wa_q.size() == 0);
    wd_fifo_empty <= (wd_q.size() == 0);
    ra_fifo_empty <= (ra_q.size() == 0);
    wa_fifo_rdata <= (wa_q.size() != 0) ? wa_q[0] : '0;
    wd_fifo_rdata <= (wd_q.size() != 0) ? wd_q[0] : '0;
    ra_fifo_rdata <= (ra_q.size() != 0) ? ra_q[0] : '0;
  end

  function automatic logic [31:0] rdv(input logic [31:0] a);
    logic [7:0] ix;
    ix = {6'b0, a[31:30]};
    return {8'hA0 + ix, a[23:0]};
  endfunction

  function automatic logic [2:0] sel_of(input logic [31:0] a);
    logic [1:0] ix;
    ix = a[31:30];
    return 3'(3'b001 << ix);
  endfunction

  task automatic push_wr(input logic [31:0] a, input logic [2:0] p,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] rsp, input bit bus);
    wa_q.push_back({p, a});
    wd_q.push_back({s, d});
    exp_b.push_back(rsp);
    if (bus) exp_acc.push_back({sel_of(a), 1'b1, p, a, d, s});
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [2:0] p,
                         input logic [33:0] e, input bit bus);
    ra_q.push_back({p, a});
    exp_r.push_back(e);
    if (bus) exp_acc.push_back({sel_of(a), 1'b0, p, a, 32'h0, 4'h0});
  endtask

  task automatic wait_for(input int nb, input int nr);
    for (int c = 0; c < 400; c++) begin
      if (act_b.size() >= nb && act_r.size() >= nr) break;
      @(negedge PCLK);
    end
  endtask

  task automatic test_reset;
    logic [1:0] eb, ab;
    acc_t ea, aa;
    PRESETn = 1'b0;
    PREADY = 3'b111;
    PSLVERR = 3'b000;
    wr_rd_ratio = 3'd2;
    rd_fifo_full = 1'b0;
    b_fifo_full = 1'b0;
    @(negedge PCLK);
    push_wr(32'h0000_0100, 3'b010, 32'h1234_5678, 4'hF, 2'b00, 1'b1);
    repeat (3) @(negedge PCLK);
    checks++;
    if ({wa_fifo_pop, wd_fifo_pop, ra_fifo_pop} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pops got=%b exp=000",
               {wa_fifo_pop, wd_fifo_pop, ra_fifo_pop});
    end
    checks++;
    if ({PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB} !== '0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0",
               {PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB});
    end
    checks++;
    if ({rd_fifo_push, b_fifo_push, rd_fifo_wdata, b_fifo_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_push got=%h exp=0",
               {rd_fifo_push, b_fifo_push, rd_fifo_wdata, b_fifo_wdata});
    end
    PRESETn = 1'b1;
    wait_for(1, 0);
    checks++;
    if (act_b.size() != 1 || acc_q.size() != 1) begin
      failures++;
      $display("FAIL reset_first_wr got=%0d/%0d exp=1/1",
               act_b.size(), acc_q.size());
    end
    while (act_b.size() != 0 && exp_b.size() != 0) begin
      eb = exp_b.pop_front();
      ab = act_b.pop_front();
      checks++;
      if (ab !== eb) begin
        failures++;
        $display("FAIL reset_bresp got=%b exp=%b", ab, eb);
      end
    end
    while (acc_q.size() != 0 && exp_acc.size() != 0) begin
      ea = exp_acc.pop_front();
      aa = acc_q.pop_front();
      checks++;
      if (aa !== ea) begin
        failures++;
        $display("FAIL reset_bus_wr got=%h exp=%h", aa, ea);
      end
    end
  endtask

  task automatic test_read;
    logic [31:0] a;
    logic [33:0] er, ar;
    acc_t ea, aa;
    @(negedge PCLK);
    for (int k = 0; k < 3; k++) begin
      a = {2'(k), 30'(32'h4 + 32'(k) * 4)};
      push_rd(a, 3'(k * 3 + 1), {2'b00, rdv(a)}, 1'b1);
    end
    wait_for(0, 3);
    checks++;
    if (act_r.size() != 3) begin
      failures++;
      $display("FAIL read_count got=%0d exp=3", act_r.size());
    end
    while (act_r.size() != 0 && exp_r.size() != 0) begin
      er = exp_r.pop_front();
      ar = act_r.pop_front();
      checks++;
      if (ar !== er) begin
        failures++;
        $display("FAIL read_data got=%h exp=%h", ar, er);
      end
    end
    while (acc_q.size() != 0 && exp_acc.size() != 0) begin
      ea = exp_acc.pop_front();
      aa = acc_q.pop_front();
      checks++;
      if (aa !== ea) begin
        failures++;
        $display("FAIL read_bus got=%h exp=%h", aa, ea);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [11:0] og, eg;
    logic [1:0]  eb, ab;
    logic [33:0] er, ar;
    acc_t ea, aa;
    wr_rd_ratio = 3'd2;
    grants.delete();
    @(negedge PCLK);
    for (int k = 0; k < 6; k++) begin
      a = {2'(k % 3), 30'(32'h100 + 32'(k) * 4)};
      push_wr(a, 3'(k), 32'hC0DE_0000 + 32'(k), 4'(k + 1), 2'b00, 1'b1);
    end
    for (int k = 0; k < 6; k++) begin
      a = {2'((k + 1) % 3), 30'(32'h200 + 32'(k) * 4)};
      push_rd(a, 3'(7 - k), {2'b00, rdv(a)}, 1'b0);
    end
    wait_for(6, 6);
    eg = 12'b1110_1110_0000;
    og = '0;
    for (int i = 0; i < 12; i++) begin
      if (i < grants.size()) og[11-i] = grants[i];
    end
    checks++;
    if (grants.size() != 12 || og !== eg) begin
      failures++;
      $display("FAIL b2b_order got=%b n=%0d exp=%b", og, grants.size(), eg);
    end
    while (act_b.size() != 0 && exp_b.size() != 0) begin
      eb = exp_b.pop_front();
      ab = act_b.pop_front();
      checks++;
      if (ab !== eb) begin
        failures++;
        $display("FAIL b2b_bresp got=%b exp=%b", ab, eb);
      end
    end
    while (act_r.size() != 0 && exp_r.size() != 0) begin
      er = exp_r.pop_front();
      ar = act_r.pop_front();
      checks++;
      if (ar !== er) begin
        failures++;
        $display("FAIL b2b_rdata got=%h exp=%h", ar, er);
      end
    end
    while (exp_acc.size() != 0) begin
      ea = exp_acc.pop_front();
      while (acc_q.size() != 0 && acc_q[0][71] !== 1'b1) acc_q.delete(0);
      aa = (acc_q.size() != 0) ? acc_q.pop_front() : '0;
      checks++;
      if (aa !== ea) begin
        failures++;
        $display("FAIL b2b_wbus got=%h exp=%h", aa, ea);
      end
    end
    acc_q.delete();
  endtask

  task automatic test_slverr;
    logic [31:0] a, d;
    logic [1:0] ab;
    acc_t ea, aa;
    int c;
    a = 32'h4000_0010;
    d = 32'hBEEF_0001;
    PREADY = 3'b101;
    PSLVERR = 3'b010;
    @(negedge PCLK);
    push_wr(a, 3'b001, d, 4'b0011, 2'b10, 1'b1);
    c = 0;
    while (PSEL === 3'b000 && c < 20) begin
      @(negedge PCLK);
      c++;
    end
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b010, 1'b0, 1'b1, a}) begin
      failures++;
      $display("FAIL slverr_setup got=%h exp=%h",
               {PSEL, PENABLE, PWRITE, PADDR}, {3'b010, 1'b0, 1'b1, a});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      checks++;
      if ({PENABLE, PSEL, PADDR, PWDATA, b_fifo_push} !==
          {1'b1, 3'b010, a, d, 1'b0}) begin
        failures++;
        $display("FAIL slverr_hold%0d got=%h exp=%h", k,
                 {PENABLE, PSEL, PADDR, PWDATA, b_fifo_push},
                 {1'b1, 3'b010, a, d, 1'b0});
      end
    end
    PREADY = 3'b111;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE} !== 4'b0000) begin
      failures++;
      $display("FAIL slverr_idle got=%b exp=0000", {PSEL, PENABLE});
    end
    wait_for(1, 0);
    ab = (act_b.size() != 0) ? act_b.pop_front() : 2'bxx;
    exp_b.delete();
    checks++;
    if (ab !== 2'b10) begin
      failures++;
      $display("FAIL slverr_resp got=%b exp=10", ab);
    end
    ea = exp_acc.pop_front();
    aa = (acc_q.size() != 0) ? acc_q.pop_front() : '0;
    checks++;
    if (aa !== ea) begin
      failures++;
      $display("FAIL slverr_bus got=%h exp=%h", aa, ea);
    end
    PSLVERR = 3'b000;
  endtask

  task automatic test_decerr;
    int seen, c;
    logic [33:0] er, ar;
    logic [1:0] eb, ab;
    @(negedge PCLK);
    push_rd(32'hC000_0000, 3'b000, {2'b11, 32'h0}, 1'b0);
    seen = 0;
    c = 0;
    while (rd_fifo_push !== 1'b1 && c < 30) begin
      if (PSEL !== 3'b000) seen++;
      @(negedge PCLK);
      c++;
    end
    checks++;
    if (rd_fifo_push !== 1'b1 || rd_fifo_wdata !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL decerr_push got=%b/%h exp=1/%h",
               rd_fifo_push, rd_fifo_wdata, {2'b11, 32'h0});
    end
    checks++;
    if (seen != 0 || PSEL !== 3'b000) begin
      failures++;
      $display("FAIL decerr_psel got=%0d exp=0", seen);
    end
    @(negedge PCLK);
    checks++;
    if (rd_fifo_push !== 1'b0) begin
      failures++;
      $display("FAIL decerr_len got=%b exp=0", rd_fifo_push);
    end
    push_wr(32'hC000_0004, 3'b000, 32'h5555_AAAA, 4'hF, 2'b11, 1'b0);
    wait_for(1, 1);
    while (act_r.size() != 0 && exp_r.size() != 0) begin
      er = exp_r.pop_front();
      ar = act_r.pop_front();
      checks++;
      if (ar !== er) begin
        failures++;
        $display("FAIL decerr_rd got=%h exp=%h", ar, er);
      end
    end
    while (act_b.size() != 0 && exp_b.size() != 0) begin
      eb = exp_b.pop_front();
      ab = act_b.pop_front();
      checks++;
      if (ab !== eb) begin
        failures++;
        $display("FAIL decerr_wr got=%b exp=%b", ab, eb);
      end
    end
  endtask

  task automatic test_timeout;
    int c, hi, nb, nr;
    logic [1:0] ab;
    logic [33:0] ar;
    PREADY = 3'b110;
    @(negedge PCLK);
    push_wr(32'h0000_0020, 3'b000, 32'h0BAD_F00D, 4'hF, 2'b10, 1'b0);
    c = 0;
    while (PENABLE !== 1'b1 && c < 30) begin
      @(negedge PCLK);
      c++;
    end
    hi = 0;
    while (PENABLE === 1'b1 && hi < 50) begin
      @(negedge PCLK);
      hi++;
    end
    checks++;
    if (hi != 8) begin
      failures++;
      $display("FAIL tmo_cycles got=%0d exp=8", hi);
    end
    wait_for(1, 0);
    ab = (act_b.size() != 0) ? act_b.pop_front() : 2'bxx;
    exp_b.delete();
    checks++;
    if (ab !== 2'b10) begin
      failures++;
      $display("FAIL tmo_wresp got=%b exp=10", ab);
    end
    push_rd(32'h0000_0030, 3'b000, {2'b10, 32'h0}, 1'b0);
    wait_for(0, 1);
    ar = (act_r.size() != 0) ? act_r.pop_front() : 'x;
    checks++;
    if (ar !== exp_r.pop_front()) begin
      failures++;
      $display("FAIL tmo_rresp got=%h exp=%h", ar, {2'b10, 32'h0});
    end
    nb = act_b.size();
    nr = act_r.size();
    ra_q.push_back({3'b110, 32'h0000_0040});
    c = 0;
    while (PENABLE !== 1'b1 && c < 30) begin
      @(negedge PCLK);
      c++;
    end
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
         rd_fifo_push, b_fifo_push} !== '0) begin
      failures++;
      $display("FAIL midrst_bus got=%h exp=0",
               {PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB});
    end
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (12) @(negedge PCLK);
    checks++;
    if (act_r.size() != nr || act_b.size() != nb || PSEL !== 3'b000) begin
      failures++;
      $display("FAIL midrst_nopush got=%0d/%0d exp=%0d/%0d",
               act_r.size(), act_b.size(), nr, nb);
    end
    PREADY = 3'b111;
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_slverr();
    test_decerr();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
